// File: rtl/dom_pkg.sv
// Shared helpers for the DOM-indep masked multiplier: randomness sizing, Z pair
// mapping, parameter legality and the normal-basis GF(2^2)/GF(2^4) products.
package dom_pkg;

    function automatic int rand_width(input int n, input int shares);
        return n * shares * (shares - 1) / 2;
    endfunction

    // Lexicographic index of pair (i,j), i<j: (0,1)=0, (0,2)=1, ..., (1,2)=shares-1
    function automatic int pair_index(input int i, input int j, input int shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic bit legal_params(input int n, input int shares, input int pipelined);
        return ((n == 1) || (n == 2) || (n == 4)) && (shares >= 2) && (shares <= 4)
            && ((pipelined == 0) || (pipelined == 1));
    endfunction

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // Multiply by the tower constant N of the GF(2^4)-over-GF(2^2) normal basis
    function automatic logic [1:0] gf4_scl_n(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        e = gf4_scl_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {gf4_mul(a[3:2], b[3:2]) ^ e, gf4_mul(a[1:0], b[1:0]) ^ e};
    endfunction

endpackage

// File: rtl/dom_reshare_reg.sv
// Enabled, synchronously reset W-bit register used for resharing and inner terms.
module dom_reshare_reg #(
    parameter int W = 4
)(
    input  logic         ClkxCI,
    input  logic         RstxRI,
    input  logic         EnxSI,
    input  logic [W-1:0] DxDI,
    output logic [W-1:0] QxDO
);

    logic [W-1:0] r_q;

    // Capture on enable, clear on reset, hold otherwise
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_q <= '0;
        end else if (EnxSI) begin
            r_q <= DxDI;
        end else begin
            r_q <= r_q;
        end
    end

    assign QxDO = r_q;

endmodule

// File: rtl/gf2_mul.sv
// Unmasked normal-basis GF(2^N) multiplier core, N in {1, 2, 4}.
module gf2_mul
    import dom_pkg::*;
#(
    parameter int N = 4
)(
    input  logic [N-1:0] XxDI,
    input  logic [N-1:0] YxDI,
    output logic [N-1:0] QxDO
);

    if (N == 1) begin : g_n1
        assign QxDO = XxDI & YxDI;
    end else if (N == 2) begin : g_n2
        assign QxDO = gf4_mul(XxDI, YxDI);
    end else begin : g_n4
        assign QxDO = gf16_mul(XxDI, YxDI);
    end

endmodule

// File: rtl/dom_indep_gf2_mul.sv
// DOM-indep masked GF(2^N) multiplier: every share-pair product, cross-domain
// terms remasked with Z and registered before recombination into the output shares.
module dom_indep_gf2_mul
    import dom_pkg::*;
#(
    parameter int N         = 4,
    parameter int SHARES    = 2,
    parameter int PIPELINED = 1
)(
    input  logic                               ClkxCI,
    input  logic                               RstxRI,
    input  logic                               EnxSI,
    input  logic [SHARES*N-1:0]                XxDI,
    input  logic [SHARES*N-1:0]                YxDI,
    input  logic [rand_width(N, SHARES)-1:0]   ZxDI,
    output logic [SHARES*N-1:0]                QxDO,
    output logic                               ValidxSO
);

    if (!legal_params(N, SHARES, PIPELINED)) begin : g_illegal
        $error("dom_indep_gf2_mul: illegal N/SHARES/PIPELINED combination");
    end

    logic [N-1:0] w_prod  [SHARES][SHARES];
    logic [N-1:0] w_reg   [SHARES][SHARES];
    logic [N-1:0] w_inner [SHARES];
    logic         r_valid;

    for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
            gf2_mul #(.N(N)) u_mul (
                .XxDI (XxDI[gi*N +: N]),
                .YxDI (YxDI[gj*N +: N]),
                .QxDO (w_prod[gi][gj])
            );

            if (gi == gj) begin : g_diag
                assign w_reg[gi][gj] = '0;
            end else begin : g_cross
                // Both domains of a pair share one Z slice so it cancels in the sum
                localparam int K = (gi < gj) ? pair_index(gi, gj, SHARES)
                                             : pair_index(gj, gi, SHARES);
                logic [N-1:0] w_cross;
                assign w_cross = w_prod[gi][gj] ^ ZxDI[K*N +: N];

                dom_reshare_reg #(.W(N)) u_reshare (
                    .ClkxCI (ClkxCI),
                    .RstxRI (RstxRI),
                    .EnxSI  (EnxSI),
                    .DxDI   (w_cross),
                    .QxDO   (w_reg[gi][gj])
                );
            end
        end

        if (PIPELINED == 1) begin : g_pipe
            dom_reshare_reg #(.W(N)) u_inner (
                .ClkxCI (ClkxCI),
                .RstxRI (RstxRI),
                .EnxSI  (EnxSI),
                .DxDI   (w_prod[gi][gi]),
                .QxDO   (w_inner[gi])
            );
        end else begin : g_comb
            assign w_inner[gi] = w_prod[gi][gi];
        end
    end

    // Recombine each domain from its inner term and its registered cross terms
    always_comb begin
        QxDO = '0;
        for (int i = 0; i < SHARES; i++) begin
            QxDO[i*N +: N] = w_inner[i];
            for (int j = 0; j < SHARES; j++) begin
                QxDO[i*N +: N] = QxDO[i*N +: N] ^ w_reg[i][j];
            end
        end
    end

    // Output-valid tracks the enable with one cycle of latency
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= EnxSI;
        end
    end

    assign ValidxSO = r_valid;

endmodule

// File: tb/tb_dom_indep_gf2_mul.sv
// Self-checking bench: four configurations of the masked multiplier against a
// log-table GF(2^2) / tower GF(2^4) reference and the DOM share equations.
module tb_dom_indep_gf2_mul;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  x1, y1, q1;
    logic [0:0]  z1;
    logic [7:0]  x4, y4, q4;
    logic [3:0]  z4;
    logic [11:0] x3, y3, z3, q3, q0;
    logic        v1, v4, v3, v0;

    logic [1:0]  s_x1, s_y1;
    logic [0:0]  s_z1;
    logic [7:0]  s_x4, s_y4;
    logic [3:0]  s_z4;
    logic [11:0] s_x3, s_y3, s_z3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dom_indep_gf2_mul #(.N(1), .SHARES(2), .PIPELINED(1)) u_n1s2 (
        .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .XxDI(x1), .YxDI(y1), .ZxDI(z1),
        .QxDO(q1), .ValidxSO(v1));
    dom_indep_gf2_mul #(.N(4), .SHARES(2), .PIPELINED(1)) u_n4s2 (
        .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .XxDI(x4), .YxDI(y4), .ZxDI(z4),
        .QxDO(q4), .ValidxSO(v4));
    dom_indep_gf2_mul #(.N(4), .SHARES(3), .PIPELINED(1)) u_n4s3 (
        .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .XxDI(x3), .YxDI(y3), .ZxDI(z3),
        .QxDO(q3), .ValidxSO(v3));
    dom_indep_gf2_mul #(.N(4), .SHARES(3), .PIPELINED(0)) u_n4s3_comb (
        .ClkxCI(clk), .RstxRI(rst), .EnxSI(en), .XxDI(x3), .YxDI(y3), .ZxDI(z3),
        .QxDO(q0), .ValidxSO(v0));

    // GF(4) in normal basis {W^2, W}: 1 = 11, W = 01, W^2 = 10; multiply via discrete logs
    function automatic int lg4(input logic [1:0] a);
        case (a)
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] ex4(input int e);
        case (e % 3)
            0:       return 2'b11;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] m_gf4(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        return ex4(lg4(a) + lg4(b));
    endfunction

    // Element = hi*Y^4 + lo*Y with Y + Y^4 = 1 and Y*Y^4 = N = W^2 (2'b10)
    function automatic logic [3:0] m_gf16(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] t;
        t = m_gf4(m_gf4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), 2'b10);
        return {m_gf4(a[3:2], b[3:2]) ^ t, m_gf4(a[1:0], b[1:0]) ^ t};
    endfunction

    function automatic logic [3:0] xsum(input logic [15:0] v, input int s);
        logic [3:0] acc = 4'h0;
        for (int i = 0; i < s; i++) acc ^= v[i*4 +: 4];
        return acc;
    endfunction

    // Expected share i: inner product plus both remasked cross terms of every pair touching i
    function automatic logic [3:0] m_share(input logic [15:0] x, input logic [15:0] y,
                                           input logic [23:0] z, input int s, input int i);
        logic [3:0] acc;
        int k = 0;
        acc = m_gf16(x[i*4 +: 4], y[i*4 +: 4]);
        for (int a = 0; a < s; a++) begin
            for (int b = a + 1; b < s; b++) begin
                if (a == i) acc ^= m_gf16(x[a*4 +: 4], y[b*4 +: 4]) ^ z[k*4 +: 4];
                if (b == i) acc ^= m_gf16(x[b*4 +: 4], y[a*4 +: 4]) ^ z[k*4 +: 4];
                k++;
            end
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand(input logic e, input logic r);
        en = e; rst = r;
        x1 = 2'($urandom);  y1 = 2'($urandom);  z1 = 1'($urandom);
        x4 = 8'($urandom);  y4 = 8'($urandom);  z4 = 4'($urandom);
        x3 = 12'($urandom); y3 = 12'($urandom); z3 = 12'($urandom);
    endtask

    task automatic save();
        s_x1 = x1; s_y1 = y1; s_z1 = z1;
        s_x4 = x4; s_y4 = y4; s_z4 = z4;
        s_x3 = x3; s_y3 = y3; s_z3 = z3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input bit with_comb);
        chk("n1_xor", 16'(q1[0] ^ q1[1]), 16'((s_x1[0] ^ s_x1[1]) & (s_y1[0] ^ s_y1[1])));
        chk("n4s2_xor", 16'(xsum(16'(q4), 2)), 16'(m_gf16(xsum(16'(s_x4), 2), xsum(16'(s_y4), 2))));
        chk("n4s3_xor", 16'(xsum(16'(q3), 3)), 16'(m_gf16(xsum(16'(s_x3), 3), xsum(16'(s_y3), 3))));
        for (int i = 0; i < 2; i++)
            chk("n4s2_share", 16'(q4[i*4 +: 4]), 16'(m_share(16'(s_x4), 16'(s_y4), 24'(s_z4), 2, i)));
        for (int i = 0; i < 3; i++)
            chk("n4s3_share", 16'(q3[i*4 +: 4]), 16'(m_share(16'(s_x3), 16'(s_y3), 24'(s_z3), 3, i)));
        if (with_comb) begin
            chk("comb_valid", 16'(v0), 16'(1));
            for (int i = 0; i < 3; i++)
                chk("comb_share", 16'(q0[i*4 +: 4]), 16'(m_share(16'(s_x3), 16'(s_y3), 24'(s_z3), 3, i)));
        end
    endtask

    initial begin
        // Reset held with enable high: everything stays cleared
        drive_rand(1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_q4", 16'(q4), 16'(0));
            chk("rst_v4", 16'(v4), 16'(0));
            chk("rst_q3", 16'(q3), 16'(0));
            chk("rst_v3", 16'(v3), 16'(0));
            chk("rst_q1", 16'(q1), 16'(0));
            drive_rand(1'b1, 1'b1);
        end
        drive_rand(1'b1, 1'b0); save();
        tick();
        chk("first_v4", 16'(v4), 16'(1));
        chk("first_v1", 16'(v1), 16'(1));
        chk_results(1'b1);

        // N=1: X0=1, X1=0, Y0=0, Y1=1, Z=1
        drive_rand(1'b1, 1'b0);
        x1 = 2'b01; y1 = 2'b10; z1 = 1'b1; save();
        tick();
        chk("n1_q0", 16'(q1[0]), 16'(0));
        chk("n1_q1", 16'(q1[1]), 16'(1));
        chk("n1_v", 16'(v1), 16'(1));
        chk_results(1'b1);
        drive_rand(1'b0, 1'b0);
        tick();
        chk("n1_v_drop", 16'(v1), 16'(0));

        // N=4, SHARES=2, Z=0: only share 0 carries the product
        drive_rand(1'b1, 1'b0);
        x4 = 8'h0A; y4 = 8'h06; z4 = 4'h0; save();
        tick();
        chk("a6_q0", 16'(q4[3:0]), 16'(m_gf16(4'hA, 4'h6)));
        chk("a6_q1", 16'(q4[7:4]), 16'(0));
        drive_rand(1'b1, 1'b0);
        x4 = 8'h00; y4 = 8'h06; z4 = 4'h0; save();
        tick();
        chk("zero_q", 16'(q4), 16'(0));

        // Continuous random stream, one result per cycle
        for (int n = 0; n < 1000; n++) begin
            drive_rand(1'b1, 1'b0); save();
            tick();
            chk("stream_v3", 16'(v3), 16'(1));
            chk_results(1'b1);
        end

        // Enable gaps: registers hold while inputs keep changing
        drive_rand(1'b0, 1'b0);
        tick();
        chk("gap_v_pre", 16'(v3), 16'(0));
        for (int k = 0; k < 4; k++) begin
            drive_rand((k == 0 || k == 3) ? 1'b1 : 1'b0, 1'b0);
            if (en) save();
            tick();
            chk("gap_v", 16'(v3), 16'((k == 0 || k == 3) ? 1 : 0));
            chk_results(1'b0);
        end

        // Reset between two enabled cycles drops the in-flight product
        drive_rand(1'b1, 1'b0); save();
        tick();
        chk_results(1'b1);
        drive_rand(1'b1, 1'b1);
        tick();
        chk("mid_rst_v3", 16'(v3), 16'(0));
        chk("mid_rst_q3", 16'(q3), 16'(0));
        chk("mid_rst_q4", 16'(q4), 16'(0));
        drive_rand(1'b1, 1'b0); save();
        tick();
        chk("post_rst_v3", 16'(v3), 16'(1));
        chk_results(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
